mem_dump_tx: RTL

//  Front-panel memory reader. It sweeps the 16x8 SAP-1 program RAM (addresses 0..F) through a read port.

---
 rtl/mem_dump_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: front-panel memory reader.
// Sweeps the program RAM from address 0 to 2**ADR_W-1 and sends each byte
// as an ASCII hex line "A: DD" CR LF over an 8N1 UART transmitter.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN adds a final "S: XX" CR LF
// line holding the modulo-256 sum of all bytes read during the dump.
module mem_dump_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADR_W        = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             rd_en,
   output logic [ADR_W-1:0] rd_adr,
   input  logic [7:0]       rd_data,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam logic [ADR_W-1:0] ADR_MAX     = '1;
   localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      LOAD,
      SHIFT,
      NEXT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  byte_reg;
   logic [2:0]  char_idx;
   logic [15:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [9:0]  shifter;
   logic [7:0]  cur_char;
   logic [3:0]  adr_nib;
   logic        line_end;
   logic        adr_last;
   logic        last_line;
   logic        bit_end;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [7:0]  sum;
   logic        sum_line;
`endif

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign adr_nib  = 4'(rd_adr);
   assign line_end = (char_idx == 3'd6);
   assign adr_last = (rd_adr == ADR_MAX);
   assign bit_end  = (baud_cnt == 16'd0) && (bit_cnt == 4'd9);
`ifdef MEM_DUMP_CHECKSUM_EN
   assign last_line = sum_line;
`else
   assign last_line = adr_last;
`endif

   // Pick the character of the current line that LOAD will frame
   always_comb begin
      cur_char = 8'h0A;
      case (char_idx)
         3'd0: begin
            cur_char = hex_char(adr_nib);
`ifdef MEM_DUMP_CHECKSUM_EN
            if (sum_line) cur_char = 8'h53;
`endif
         end
         3'd1:    cur_char = 8'h3A;
         3'd2:    cur_char = 8'h20;
         3'd3:    cur_char = hex_char(byte_reg[7:4]);
         3'd4:    cur_char = hex_char(byte_reg[3:0]);
         3'd5:    cur_char = 8'h0D;
         default: cur_char = 8'h0A;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state decode and the RAM read strobe
   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      case (state)
         IDLE:  if (start) state_next = FETCH;
         FETCH: begin
            rd_en      = 1'b1;
            state_next = LATCH;
         end
         LATCH: state_next = LOAD;
         LOAD:  state_next = SHIFT;
         SHIFT: if (bit_end) state_next = NEXT;
         NEXT: begin
            if (!line_end)     state_next = LOAD;
            else if (last_line) state_next = IDLE;
`ifdef MEM_DUMP_CHECKSUM_EN
            else if (adr_last) state_next = LOAD;
`endif
            else               state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: address, byte capture, character framing, baud timing, status
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_adr   <= '0;
         byte_reg <= 8'h00;
         char_idx <= 3'd0;
         baud_cnt <= 16'd0;
         bit_cnt  <= 4'd0;
         shifter  <= 10'h3FF;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum      <= 8'h00;
         sum_line <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rd_adr <= '0;
                  busy   <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                  sum      <= 8'h00;
                  sum_line <= 1'b0;
`endif
               end
            end
            LATCH: begin
               byte_reg <= rd_data;
               char_idx <= 3'd0;
`ifdef MEM_DUMP_CHECKSUM_EN
               sum <= sum + rd_data;
`endif
            end
            LOAD: begin
               shifter  <= {1'b1, cur_char, 1'b0};
               tx       <= 1'b0;
               baud_cnt <= BAUD_RELOAD;
            end
            SHIFT: begin
               if (baud_cnt != 16'd0) begin
                  baud_cnt <= baud_cnt - 16'd1;
               end else if (bit_cnt != 4'd9) begin
                  shifter  <= {1'b1, shifter[9:1]};
                  tx       <= shifter[1];
                  bit_cnt  <= bit_cnt + 4'd1;
                  baud_cnt <= BAUD_RELOAD;
               end
            end
            NEXT: begin
               bit_cnt <= 4'd0;
               if (!line_end) begin
                  char_idx <= char_idx + 3'd1;
               end else if (last_line) begin
                  busy <= 1'b0;
                  done <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
               end else if (adr_last) begin
                  sum_line <= 1'b1;
                  byte_reg <= sum;
                  char_idx <= 3'd0;
`endif
               end else begin
                  rd_adr <= rd_adr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
